draw_sequencer: RTL and testbench

Raster sequencer that owns the pixel-drawing datapath of the game display. It accepts one draw request at a time: clear to black, full-screen image, or a 40x40 battle sprite at a table-selected origin. It then walks every pixel of the target region, issuing sprite/screen ROM addresses and producing plot strobes with x, y, colour-source select and black-override aligned to ROM read data. It sits between the game FSM (requester) and the colour mux / VGA adapter.

---
 rtl/draw_sequencer.sv | 171 +++++++++++++++++
 tb/tb_draw_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_sequencer.sv
// Raster sequencer: walks a clear/full-screen/sprite region and issues ROM addresses,
// with plot, x, y, black and colour-source select delayed one cycle to line up with ROM data.
module draw_sequencer #(
    parameter int unsigned SCREEN_W = 160,
    parameter int unsigned SCREEN_H = 120,
    parameter int unsigned SPRITE_W = 40,
    parameter int unsigned SPRITE_H = 40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [1:0]  req_kind,
    input  logic [4:0]  req_mem,
    input  logic [3:0]  req_xsel,
    input  logic [1:0]  req_ysel,
    output logic        busy,
    output logic        done,
    output logic [14:0] address,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic        plot,
    output logic        black,
    output logic [4:0]  memory_sel
);

    localparam int unsigned COL_W  = 8;
    localparam int unsigned ROW_W  = 7;
    localparam int unsigned ADDR_W = 15;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SCAN  = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t             state;
    logic [1:0]         kind_q;
    logic [4:0]         mem_q;
    logic [3:0]         xsel_q;
    logic [1:0]         ysel_q;
    logic [COL_W-1:0]   x0_q;
    logic [ROW_W-1:0]   y0_q;
    logic [COL_W-1:0]   width_q;
    logic [ROW_W-1:0]   height_q;
    logic [COL_W-1:0]   col_q;
    logic [ROW_W-1:0]   row_q;

    logic last_col;
    logic last_row;
    logic kind_black;

    // Sprite x origin for each battle slot
    function automatic logic [COL_W-1:0] x_origin(input logic [3:0] sel);
        case (sel)
            4'd1:    x_origin = COL_W'(36);
            4'd2:    x_origin = COL_W'(30);
            4'd3:    x_origin = COL_W'(24);
            4'd4:    x_origin = COL_W'(18);
            4'd5:    x_origin = COL_W'(12);
            4'd6:    x_origin = COL_W'(6);
            4'd8:    x_origin = COL_W'(90);
            4'd9:    x_origin = COL_W'(96);
            4'd10:   x_origin = COL_W'(102);
            4'd11:   x_origin = COL_W'(108);
            4'd12:   x_origin = COL_W'(114);
            4'd13:   x_origin = COL_W'(120);
            default: x_origin = COL_W'(0);
        endcase
    endfunction

    function automatic logic [ROW_W-1:0] y_origin(input logic [1:0] sel);
        y_origin = (sel == 2'd1) ? ROW_W'(30) : ROW_W'(0);
    endfunction

    assign last_col   = (col_q == width_q - COL_W'(1));
    assign last_row   = (row_q == height_q - ROW_W'(1));
    // Reserved kind 3 behaves as clear-to-black
    assign kind_black = (kind_q == 2'd0) || (kind_q == 2'd3);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            kind_q     <= 2'd0;
            mem_q      <= 5'd0;
            xsel_q     <= 4'd0;
            ysel_q     <= 2'd0;
            x0_q       <= '0;
            y0_q       <= '0;
            width_q    <= '0;
            height_q   <= '0;
            col_q      <= '0;
            row_q      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            address    <= '0;
            x          <= '0;
            y          <= '0;
            plot       <= 1'b0;
            black      <= 1'b0;
            memory_sel <= 5'd0;
        end else begin
            done  <= 1'b0;
            plot  <= 1'b0;
            black <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        kind_q <= req_kind;
                        mem_q  <= req_mem;
                        xsel_q <= req_xsel;
                        ysel_q <= req_ysel;
                        busy   <= 1'b1;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    if (kind_q == 2'd2) begin
                        x0_q     <= x_origin(xsel_q);
                        y0_q     <= y_origin(ysel_q);
                        width_q  <= COL_W'(SPRITE_W);
                        height_q <= ROW_W'(SPRITE_H);
                    end else begin
                        x0_q     <= '0;
                        y0_q     <= '0;
                        width_q  <= COL_W'(SCREEN_W);
                        height_q <= ROW_W'(SCREEN_H);
                    end
                    col_q   <= '0;
                    row_q   <= '0;
                    address <= '0;
                    state   <= SCAN;
                end
                SCAN: begin
                    // Pixel strobe for the address on the bus this cycle lands next cycle
                    plot       <= 1'b1;
                    black      <= kind_black;
                    x          <= x0_q + col_q;
                    y          <= y0_q + row_q;
                    memory_sel <= mem_q;
                    if (last_col) begin
                        col_q <= '0;
                        if (last_row) begin
                            state <= FLUSH;
                        end else begin
                            row_q   <= row_q + ROW_W'(1);
                            address <= address + ADDR_W'(1);
                        end
                    end else begin
                        col_q   <= col_q + COL_W'(1);
                        address <= address + ADDR_W'(1);
                    end
                end
                FLUSH: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_draw_sequencer.sv
// Bench for draw_sequencer: cycle-indexed timeline model per accepted request,
// compared against every DUT output on each falling edge, plus literal spot checks.
module tb_draw_sequencer;

    localparam int SW = 160;
    localparam int SH = 120;
    localparam int PW = 40;
    localparam int PH = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0;
    logic [1:0]  req_kind = 2'd0;
    logic [4:0]  req_mem = 5'd0;
    logic [3:0]  req_xsel = 4'd0;
    logic [1:0]  req_ysel = 2'd0;
    logic        busy, done, plot, black;
    logic [14:0] address;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [4:0]  memory_sel;

    draw_sequencer dut (
        .clk(clk), .reset(reset), .req(req), .req_kind(req_kind), .req_mem(req_mem),
        .req_xsel(req_xsel), .req_ysel(req_ysel), .busy(busy), .done(done),
        .address(address), .x(x), .y(y), .plot(plot), .black(black),
        .memory_sel(memory_sel)
    );

    always #5 clk = ~clk;

    int xt [16] = '{0, 36, 30, 24, 18, 12, 6, 0, 90, 96, 102, 108, 114, 120, 0, 0};
    int yt [4]  = '{0, 30, 0, 0};

    // Model: k = cycles since the accepting edge (LOAD is k=1); held output values
    bit m_active = 1'b0;
    int m_k = 0, m_n = 1, m_w = 1, m_x0 = 0, m_y0 = 0, m_kind = 0, m_mem = 0;
    int h_addr = 0, h_x = 0, h_y = 0, h_msel = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_active <= 1'b0;
            m_k      <= 0;
            h_addr   <= 0;
            h_x      <= 0;
            h_y      <= 0;
            h_msel   <= 0;
        end else if (!m_active) begin
            if (req) begin
                m_active <= 1'b1;
                m_k      <= 1;
                m_kind   <= int'(req_kind);
                m_mem    <= int'(req_mem);
                m_x0     <= (req_kind == 2'd2) ? xt[req_xsel] : 0;
                m_y0     <= (req_kind == 2'd2) ? yt[req_ysel] : 0;
                m_w      <= (req_kind == 2'd2) ? PW : SW;
                m_n      <= (req_kind == 2'd2) ? PW * PH : SW * SH;
            end
        end else begin
            m_k <= m_k + 1;
            if (m_k + 1 == m_n + 4) m_active <= 1'b0;
            if (m_k + 1 >= 2 && m_k + 1 <= m_n + 1) h_addr <= m_k - 1;
            if (m_k + 1 >= 3 && m_k + 1 <= m_n + 2) begin
                h_x    <= m_x0 + (m_k - 2) % m_w;
                h_y    <= m_y0 + (m_k - 2) / m_w;
                h_msel <= m_mem;
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    int st_plots, st_first_x, st_first_y, st_first_addr, st_w39x, st_w39y, st_w40x, st_w40y;
    int st_last_x, st_last_y, st_last_addr, st_minx, st_maxx, st_black, st_msel_bad;
    int st_done_at, st_done_cnt, prev_addr;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One falling edge: compare all outputs against the model, then gather statistics
    task automatic cycle();
        logic [38:0] act, exp;
        logic eb, ed, ep, ebl;
        @(negedge clk);
        eb  = m_active && m_k >= 1 && m_k <= m_n + 2;
        ed  = m_active && m_k == m_n + 3;
        ep  = m_active && m_k >= 3 && m_k <= m_n + 2;
        ebl = ep && (m_kind == 0 || m_kind == 3);
        exp = {eb, ed, ep, ebl, 15'(h_addr), 8'(h_x), 7'(h_y), 5'(h_msel)};
        act = {busy, done, plot, black, address, x, y, memory_sel};
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL outputs t=%0t got busy/done/plot/black=%b%b%b%b addr=%0d x=%0d y=%0d sel=%0d expected %b%b%b%b addr=%0d x=%0d y=%0d sel=%0d",
                     $time, busy, done, plot, black, address, x, y, memory_sel,
                     eb, ed, ep, ebl, h_addr, h_x, h_y, h_msel);
        end
        if (m_active && m_k == 1) begin
            st_plots = 0; st_black = 0; st_msel_bad = 0; st_done_cnt = 0; st_done_at = -1;
            st_minx = 999; st_maxx = -1;
        end
        if (plot) begin
            if (st_plots == 0) begin
                st_first_x = int'(x); st_first_y = int'(y); st_first_addr = prev_addr;
            end
            if (st_plots == 39) begin st_w39x = int'(x); st_w39y = int'(y); end
            if (st_plots == 40) begin st_w40x = int'(x); st_w40y = int'(y); end
            st_last_x = int'(x); st_last_y = int'(y); st_last_addr = prev_addr;
            if (int'(x) < st_minx) st_minx = int'(x);
            if (int'(x) > st_maxx) st_maxx = int'(x);
            if (black) st_black++;
            if (int'(memory_sel) != m_mem) st_msel_bad++;
            st_plots++;
        end
        if (done) begin
            st_done_cnt++;
            st_done_at = m_k;
        end
        prev_addr = int'(address);
    endtask

    task automatic start(input logic [1:0] k, input logic [4:0] m, input logic [3:0] xs,
                         input logic [1:0] ys);
        req = 1'b1; req_kind = k; req_mem = m; req_xsel = xs; req_ysel = ys;
        cycle();
        req = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int i = 0;
        while (m_active && i < budget) begin
            cycle();
            i++;
        end
        n_cmp++;
        if (m_active) begin
            n_bad++;
            $display("FAIL idle_timeout: still active after %0d cycles", budget);
        end
    endtask

    initial begin
        #15_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] xs;
        logic [1:0] ys;
        int i;
        #1 reset = 1'b1;
        repeat (3) cycle();
        reset = 1'b0;
        repeat (10) cycle();
        check("idle_busy", busy, 0);
        check("idle_plot", plot, 0);

        // Reset asserted mid-idle
        reset = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_plot", plot, 0);
        check("rst_black", black, 0);
        check("rst_addr", address, 0);
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_msel", memory_sel, 0);
        cycle();
        reset = 1'b0;
        cycle();

        // Sprite at slot (8,1)
        start(2'd2, 5'b01010, 4'd8, 2'd1);
        wait_idle(2000);
        check("spr_plots", st_plots, 1600);
        check("spr_first_x", st_first_x, 90);
        check("spr_first_y", st_first_y, 30);
        check("spr_first_addr", st_first_addr, 0);
        check("spr_wrap_prev_x", st_w39x, 129);
        check("spr_wrap_prev_y", st_w39y, 30);
        check("spr_wrap_next_x", st_w40x, 90);
        check("spr_wrap_next_y", st_w40y, 31);
        check("spr_last_x", st_last_x, 129);
        check("spr_last_y", st_last_y, 69);
        check("spr_last_addr", st_last_addr, 1599);
        check("spr_done_at", st_done_at, 1603);
        check("spr_done_cnt", st_done_cnt, 1);
        check("spr_black", st_black, 0);
        check("spr_msel_bad", st_msel_bad, 0);

        // Clear screen
        start(2'd0, 5'($urandom), 4'($urandom), 2'($urandom));
        wait_idle(20000);
        check("clr_plots", st_plots, 19200);
        check("clr_first_x", st_first_x, 0);
        check("clr_first_y", st_first_y, 0);
        check("clr_last_x", st_last_x, 159);
        check("clr_last_y", st_last_y, 119);
        check("clr_last_addr", st_last_addr, 19199);
        check("clr_black", st_black, 19200);
        check("clr_done_at", st_done_at, 19203);

        // Right-edge sprite and the zero-origin slot
        start(2'd2, 5'd3, 4'd13, 2'd0);
        wait_idle(2000);
        check("edge_minx", st_minx, 120);
        check("edge_maxx", st_maxx, 159);
        check("edge_last_y", st_last_y, 39);
        start(2'd2, 5'd4, 4'd14, 2'd2);
        wait_idle(2000);
        check("x14_first_x", st_first_x, 0);
        check("x14_first_y", st_first_y, 0);
        check("x14_last_x", st_last_x, 39);
        check("x14_last_y", st_last_y, 39);

        // Requests while busy are ignored; one held through DONE is taken in IDLE
        start(2'd2, 5'd6, 4'd5, 2'd1);
        repeat (100) cycle();
        req = 1'b1; req_kind = 2'd1;
        cycle();
        req = 1'b0;
        i = 0;
        while (m_k < 1500 && i < 2000) begin cycle(); i++; end
        req = 1'b1; req_kind = 2'd2; req_xsel = 4'd9; req_ysel = 2'd0; req_mem = 5'd17;
        i = 0;
        while (done !== 1'b1 && i < 500) begin cycle(); i++; end
        check("rej_plots", st_plots, 1600);
        check("rej_done_at", st_done_at, 1603);
        check("rej_first_x", st_first_x, 12);
        cycle();
        check("held_idle_busy", busy, 0);
        cycle();
        check("held_load_busy", busy, 1);
        req = 1'b0;
        wait_idle(2000);
        check("held_plots", st_plots, 1600);
        check("held_first_x", st_first_x, 96);
        check("held_first_y", st_first_y, 0);

        // Abort mid-sprite
        start(2'd2, 5'd7, 4'd4, 2'd1);
        i = 0;
        while (st_plots < 500 && i < 1000) begin cycle(); i++; end
        reset = 1'b1;
        #1;
        check("abort_plot", plot, 0);
        check("abort_busy", busy, 0);
        check("abort_addr", address, 0);
        cycle();
        cycle();
        reset = 1'b0;
        repeat (5) cycle();
        check("abort_plots", st_plots, 500);
        check("abort_no_done", st_done_cnt, 0);
        start(2'd2, 5'd7, 4'd4, 2'd1);
        wait_idle(2000);
        check("rerun_plots", st_plots, 1600);
        check("rerun_first_addr", st_first_addr, 0);
        check("rerun_first_x", st_first_x, 18);
        check("rerun_first_y", st_first_y, 30);
        check("rerun_done_at", st_done_at, 1603);

        // Reserved kind draws the full screen in black
        start(2'd3, 5'($urandom), 4'($urandom), 2'($urandom));
        wait_idle(20000);
        check("k3_plots", st_plots, 19200);
        check("k3_black", st_black, 19200);
        check("k3_last_x", st_last_x, 159);
        check("k3_last_y", st_last_y, 119);

        // Random sprites with random request noise while busy
        for (int r = 0; r < 8; r++) begin
            xs = 4'($urandom_range(0, 15));
            ys = 2'($urandom_range(0, 3));
            start(2'd2, 5'($urandom), xs, ys);
            i = 0;
            while (m_active && i < 3000) begin
                if (m_k < m_n) begin
                    req = ($urandom % 4) == 0;
                    req_kind = 2'($urandom);
                    req_mem = 5'($urandom);
                end else begin
                    req = 1'b0;
                end
                cycle();
                i++;
            end
            req = 1'b0;
            check("rnd_plots", st_plots, 1600);
            check("rnd_minx", st_minx, xt[xs]);
            check("rnd_maxx", st_maxx, xt[xs] + 39);
            check("rnd_first_y", st_first_y, yt[ys]);
            check("rnd_last_y", st_last_y, yt[ys] + 39);
            check("rnd_done_at", st_done_at, 1603);
            check("rnd_msel_bad", st_msel_bad, 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
